// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared synchronous memory port.
// Each access is an address phase followed by a response phase; lock allows bounded bursts.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [3:0] mem_exception_mask_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req,
    input  logic [1:0]          m_lock,
    input  logic [31:0]         m0_addr,
    input  logic [31:0]         m1_addr,
    input  logic [31:0]         m0_wr_data,
    input  logic [31:0]         m1_wr_data,
    input  logic                m0_wr_ena,
    input  logic                m1_wr_ena,
    input  mem_access_t         m0_access,
    input  mem_access_t         m1_access,
    output logic [1:0]          m_gnt,
    output logic [1:0]          m_done,
    output logic [31:0]         m_rd_data,
    output mem_exception_mask_t m_exception,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [31:0]         mem_rd_data,
    input  mem_exception_mask_t mem_exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

    state_t              state;
    logic                owner;
    logic                last_owner;
    logic [7:0]          burst_cnt;
    mem_exception_mask_t exc_q;

    logic own_req;
    logic own_lock;
    logic oth_req;
    logic pick;

    assign own_req  = m_req[owner];
    assign own_lock = m_lock[owner];
    assign oth_req  = m_req[~owner];
    // A lone requester wins; on a tie the master that was not served last wins.
    assign pick     = (m_req == 2'b11) ? ~last_owner : m_req[1];

    // Sequencer: address phase, response phase, then re-arbitrate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            burst_cnt  <= 8'd0;
            exc_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|m_req) begin
                        owner     <= pick;
                        burst_cnt <= 8'd0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    exc_q <= mem_exception;
                    state <= RESP;
                end
                RESP: begin
                    last_owner <= owner;
                    if (own_req && own_lock && burst_cnt < BURST_LIM) begin
                        if (burst_cnt != 8'hFF) begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                        state <= ADDR;
                    end else if (oth_req) begin
                        owner     <= ~owner;
                        burst_cnt <= 8'd0;
                        state     <= ADDR;
                    end else if (own_req) begin
                        burst_cnt <= 8'd0;
                        state     <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port muxing and handshake outputs decoded from the sequencer state.
    always_comb begin
        m_gnt       = 2'b00;
        m_done      = 2'b00;
        m_rd_data   = '0;
        m_exception = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        mem_access  = MEM_ACCESS_WORD;
        unique case (state)
            ADDR: begin
                m_gnt       = owner ? 2'b10 : 2'b01;
                mem_addr    = owner ? m1_addr : m0_addr;
                mem_wr_data = owner ? m1_wr_data : m0_wr_data;
                mem_wr_ena  = owner ? m1_wr_ena : m0_wr_ena;
                mem_access  = owner ? m1_access : m0_access;
            end
            RESP: begin
                m_gnt       = owner ? 2'b10 : 2'b01;
                m_done      = owner ? 2'b10 : 2'b01;
                m_rd_data   = mem_rd_data;
                m_exception = exc_q;
            end
            default: begin
            end
        endcase
    end

endmodule
